// File: rtl/acond_pkg.sv
// Shared constants for the external square-wave front end: FSM states and
// board-clock defaults for the prescaler and loss-of-signal timeout.
package acond_pkg;

  typedef enum logic [1:0] {
    ST_ESPERA  = 2'd0,
    ST_ACTIVA  = 2'd1,
    ST_PERDIDA = 2'd2
  } estado_t;

  // 50 MHz board clock: one tick per microsecond, 255 us without a rising edge
  localparam int PRESC_DEF   = 50;
  localparam int TIMEOUT_DEF = 255;
  localparam int TO_W_DEF    = 8;

endpackage

// File: rtl/sincronizador.sv
// Flop chain bringing an asynchronous level into the clk domain; shared with
// the push-button inputs.
module sincronizador #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] cadena;

  always_ff @(posedge clk) begin
    if (reset) begin
      cadena <= '0;
    end else begin
      cadena <= {cadena[SYNC_STAGES-2:0], d};
    end
  end

  assign q = cadena[SYNC_STAGES-1];

endmodule

// File: rtl/acondicionador_senal.sv
// Front end for the period counter: synchronises and deglitches the external
// square wave, emits edge strobes, a time-base tick and a loss-of-signal flag.
module acondicionador_senal
  import acond_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_LEN    = 4,
  parameter int PRESC         = PRESC_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_DEF,
  parameter int TO_W          = TO_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_senal,
  output logic o_nivel,
  output logic o_flanco_sub,
  output logic o_flanco_baj,
  output logic o_glitch,
  output logic o_tick,
  output logic o_sin_senal
);

  localparam int F_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int P_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [F_W-1:0]  F_LAST  = F_W'(FILTER_LEN - 1);
  localparam logic [P_W-1:0]  P_LAST  = P_W'(PRESC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic            s;
  logic [F_W-1:0]  cnt_f;
  logic [P_W-1:0]  cnt_p;
  logic [TO_W-1:0] cnt_to, cnt_to_sig;
  estado_t         estado, estado_sig;

  sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sinc (
    .clk  (clk),
    .reset(reset),
    .d    (i_senal),
    .q    (s)
  );

  // Level filter: the synchronised input must disagree with o_nivel for
  // FILTER_LEN consecutive clocks before the level flips.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_nivel      <= 1'b0;
      cnt_f        <= '0;
      o_flanco_sub <= 1'b0;
      o_flanco_baj <= 1'b0;
      o_glitch     <= 1'b0;
    end else begin
      o_flanco_sub <= 1'b0;
      o_flanco_baj <= 1'b0;
      o_glitch     <= 1'b0;
      if (s != o_nivel) begin
        if (cnt_f == F_LAST) begin
          o_nivel      <= s;
          cnt_f        <= '0;
          o_flanco_sub <= s;
          o_flanco_baj <= ~s;
        end else begin
          cnt_f <= cnt_f + 1'b1;
        end
      end else begin
        cnt_f    <= '0;
        o_glitch <= (cnt_f != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p  <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= (cnt_p == P_LAST);
      cnt_p  <= (cnt_p == P_LAST) ? '0 : cnt_p + 1'b1;
    end
  end

  // Loss-of-signal FSM driven by the registered strobe and tick; a rising
  // strobe always wins over a tick arriving in the same cycle.
  always_comb begin
    estado_sig = estado;
    cnt_to_sig = cnt_to;
    case (estado)
      ST_ESPERA, ST_PERDIDA: begin
        if (o_flanco_sub) begin
          estado_sig = ST_ACTIVA;
          cnt_to_sig = '0;
        end
      end
      ST_ACTIVA: begin
        if (o_flanco_sub) begin
          cnt_to_sig = '0;
        end else if (o_tick) begin
          if (cnt_to == TO_LAST) begin
            estado_sig = ST_PERDIDA;
            cnt_to_sig = '0;
          end else begin
            cnt_to_sig = cnt_to + 1'b1;
          end
        end
      end
      default: begin
        estado_sig = ST_ESPERA;
        cnt_to_sig = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado      <= ST_ESPERA;
      cnt_to      <= '0;
      o_sin_senal <= 1'b1;
    end else begin
      estado      <= estado_sig;
      cnt_to      <= cnt_to_sig;
      o_sin_senal <= (estado_sig != ST_ACTIVA);
    end
  end

endmodule

// File: tb/tb_acondicionador_senal.sv
// Randomised and directed bench for acondicionador_senal against a cycle-level
// behavioural model of the signal conditioner.
module tb_acondicionador_senal;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int PR   = 4;
  localparam int TO   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_senal = 1'b0;
  logic o_nivel, o_flanco_sub, o_flanco_baj, o_glitch, o_tick, o_sin_senal;

  int errors = 0;
  int checks = 0;

  acondicionador_senal #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .PRESC(PR), .TIMEOUT_TICKS(TO), .TO_W(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_senal     (i_senal),
    .o_nivel     (o_nivel),
    .o_flanco_sub(o_flanco_sub),
    .o_flanco_baj(o_flanco_baj),
    .o_glitch    (o_glitch),
    .o_tick      (o_tick),
    .o_sin_senal (o_sin_senal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: s is the input sampled SYNC clocks earlier; the level
  // follows s once it has disagreed for FILT consecutive clocks; a tick follows
  // every PR-th clock since reset; signal is lost after TO ticks with no rise.
  logic hist [SYNC];
  logic m_lvl, m_sub, m_baj, m_gl, m_tick, m_sin;
  int   m_run, m_cyc, m_nt;
  bit   m_act;

  task automatic model_step();
    logic s_b;
    if (reset) begin
      for (int k = 0; k < SYNC; k++) hist[k] = 1'b0;
      m_lvl = 0; m_sub = 0; m_baj = 0; m_gl = 0; m_tick = 0; m_sin = 1;
      m_run = 0; m_cyc = 0; m_nt = 0; m_act = 0;
    end else begin
      if (m_sub) begin
        m_act = 1; m_nt = 0;
      end else if (m_act && m_tick) begin
        m_nt++;
        if (m_nt == TO) begin
          m_act = 0; m_nt = 0;
        end
      end
      m_sin = !m_act;
      s_b = hist[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = i_senal;
      m_sub = 0; m_baj = 0; m_gl = 0;
      if (s_b !== m_lvl) begin
        m_run++;
        if (m_run == FILT) begin
          m_lvl = s_b; m_run = 0; m_sub = s_b; m_baj = !s_b;
        end
      end else begin
        m_gl = (m_run != 0);
        m_run = 0;
      end
      m_cyc++;
      m_tick = ((m_cyc % PR) == 0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("nivel", o_nivel, m_lvl);
      chk("flanco_sub", o_flanco_sub, m_sub);
      chk("flanco_baj", o_flanco_baj, m_baj);
      chk("glitch", o_glitch, m_gl);
      chk("tick", o_tick, m_tick);
      chk("sin_senal", o_sin_senal, m_sin);
    end
  end

  initial begin
    int nt, nsub, nbaj, ngl, nhi, last_sub, last_baj, hold;
    bit got;

    // Reset held 3 clocks
    reset = 1'b1; i_senal = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sin", o_sin_senal, 1'b1);
    chk("rst_nivel", o_nivel, 1'b0);
    chk("rst_tick", o_tick, 1'b0);
    chk("rst_sub", o_flanco_sub, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      chk("tick_period", o_tick, (k == 4) || (k == 8));
    end

    // Rising edge: strobe 6 clocks after the first sampling edge
    @(negedge clk); i_senal = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #2;
      chk("rise_sub", o_flanco_sub, k == 6);
      chk("rise_nivel", o_nivel, k >= 6);
      chk("rise_sin", o_sin_senal, k < 7);
    end

    // Input stays high: signal lost after the 3rd following tick
    nt = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #2;
      if (o_sin_senal) got = 1;
      else if (o_tick) nt++;
    end
    chk("timeout_seen", got, 1'b1);
    chk_int("timeout_ticks", nt, TO);

    // Next valid rising edge clears it
    @(negedge clk); i_senal = 1'b0;
    repeat (12) @(negedge clk);
    i_senal = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #2;
      if (k == 6) chk("recover_before", o_sin_senal, 1'b1);
      if (k == 7) chk("recover_after", o_sin_senal, 1'b0);
    end

    // 2-clock pulse from level 0: one glitch, no level change
    @(negedge clk); i_senal = 1'b0;
    repeat (12) @(negedge clk);
    i_senal = 1'b1;
    repeat (2) @(negedge clk);
    i_senal = 1'b0;
    ngl = 0; nsub = 0; nhi = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      ngl += int'(o_glitch); nsub += int'(o_flanco_sub); nhi += int'(o_nivel);
    end
    chk_int("glitch_count", ngl, 1);
    chk_int("glitch_sub", nsub, 0);
    chk_int("glitch_nivel", nhi, 0);

    // Square wave, period 20, 50% duty
    nsub = 0; nbaj = 0; last_sub = -1; last_baj = -1;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      i_senal = (k < 120) ? ((k % 20) < 10) : 1'b0;
      @(posedge clk); #2;
      if (o_flanco_sub) begin
        if (last_sub >= 0) chk_int("rise_spacing", k - last_sub, 20);
        nsub++; last_sub = k;
      end
      if (o_flanco_baj) begin
        if (last_sub >= 0) chk_int("rise_fall_spacing", k - last_sub, 10);
        nbaj++; last_baj = k;
      end
    end
    chk_int("square_rises", nsub, 6);
    chk_int("square_falls", nbaj, 6);

    // Rising strobe coincides with a tick: strobe wins, timeout restarts
    @(negedge clk); reset = 1'b1; i_senal = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    i_senal = 1'b1;
    for (int p = 3; p <= 21; p++) begin
      @(posedge clk); #2;
      if (p == 8) begin
        chk("collide_sub", o_flanco_sub, 1'b1);
        chk("collide_tick", o_tick, 1'b1);
      end
      if (p == 20) chk("collide_sin_hold", o_sin_senal, 1'b0);
      if (p == 21) chk("collide_sin_lost", o_sin_senal, 1'b1);
    end

    // Reset asserted mid-filter with the input high
    @(negedge clk); i_senal = 1'b0;
    repeat (12) @(negedge clk);
    i_senal = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #2;
      chk("mid_reset_sub", o_flanco_sub, k == 6);
    end

    // Random stimulus with occasional reset pulses
    hold = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
      end
      if (hold == 0) begin
        i_senal = ~i_senal;
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
      end
      hold--;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
